sat_assignment_checker: RTL and testbench

- Verifies a candidate variable assignment against the stored 2-SAT clause set. It is the reader/checker end of the clause store.
- Sequentially reads every clause through a registered-read port (1-cycle latency, same timing as the clause store outputs) and evaluates each literal against the assignment.
- Reports satisfiability, the failing-clause count, the first failing clause, and illegal literals.
- Sits beside the SCC solver: the solver's derived assignment is fed in, and this block confirms or refutes it.

---
 rtl/sat_assignment_checker.sv | 197 +++++++++++++++++++
 tb/tb_sat_assignment_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sat_assignment_checker.sv
// ---------------------------------------------------------------------------
// sat_assignment_checker
//
// Checks a candidate variable assignment against the 2-SAT clause store. It
// walks every clause address once through a registered-read port and
// evaluates both literals against the latched assignment. It reports whether
// the assignment satisfies the clause set, how many clauses fail, and the
// lowest failing clause index. It also flags literals that cannot refer to
// any variable.
//
// Ports:
//   clk             clock
//   reset_n         synchronous active-low reset
//   start           request a check (sampled only while idle)
//   assign_val      candidate assignment, bit i = value of variable i+1
//                   ("assign" is a reserved word, so the port carries a suffix)
//   rd_en           clause read strobe
//   rd_addr         clause index being read
//   rd_var1/rd_var2 signed literals returned one cycle after rd_en
//   busy            high while a check is in flight
//   done            one-cycle pulse when the results are final
//   sat             every clause satisfied and no illegal literal
//   fail_count      number of unsatisfied clauses
//   first_fail_addr lowest failing clause index (0 if none)
//   invalid_lit     a literal was 0 or outside +/-1..+/-NUM_VARS
// ---------------------------------------------------------------------------
module sat_assignment_checker #(
    parameter int CLAUSE_SIZE = 4,
    parameter int NUM_VARS    = 3,
    parameter int LIT_W       = 8,
    localparam int AW = (CLAUSE_SIZE > 1) ? $clog2(CLAUSE_SIZE) : 1,
    localparam int FW = $clog2(CLAUSE_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [NUM_VARS-1:0]     assign_val,
    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr,
    input  logic signed [LIT_W-1:0] rd_var1,
    input  logic signed [LIT_W-1:0] rd_var2,
    output logic                    busy,
    output logic                    done,
    output logic                    sat,
    output logic [FW-1:0]           fail_count,
    output logic [AW-1:0]           first_fail_addr,
    output logic                    invalid_lit
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [AW-1:0]           LAST_ADDR = AW'(CLAUSE_SIZE - 1);
    localparam logic [FW-1:0]           FC_MAX    = FW'(CLAUSE_SIZE);
    localparam logic signed [LIT_W-1:0] MAX_LIT   = LIT_W'(NUM_VARS);
    localparam logic signed [LIT_W-1:0] MIN_LIT   = -MAX_LIT;

    state_t                state_reg, state_next;
    logic [NUM_VARS-1:0]   assign_reg;
    logic [AW-1:0]         addr_reg;
    logic [AW-1:0]         tag_reg;
    logic                  valid_reg;
    logic                  sat_reg;
    logic                  invalid_reg;
    logic [FW-1:0]         fail_count_reg;
    logic [AW-1:0]         first_fail_reg;

    logic [FW-1:0]         fail_count_next;
    logic [AW-1:0]         first_fail_next;
    logic                  invalid_next;

    logic                  accept;
    logic signed [LIT_W-1:0] lit [2];
    logic [1:0]            lit_ok;
    logic [1:0]            lit_val;
    logic                  clause_fail;
    logic                  lit_bad;

    assign accept = (state_reg == IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (addr_reg == LAST_ADDR) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en = (state_reg == ISSUE);
        busy  = (state_reg == ISSUE) || (state_reg == DRAIN);
        done  = (state_reg == DONE);
    end

    assign rd_addr         = addr_reg;
    assign sat             = sat_reg;
    assign fail_count      = fail_count_reg;
    assign first_fail_addr = first_fail_reg;
    assign invalid_lit     = invalid_reg;

    // ---------------- Literal evaluation ----------------
    assign lit[0] = rd_var1;
    assign lit[1] = rd_var2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lit
            logic [LIT_W-1:0] mag;
            logic             hit;

            // Magnitude of the literal; -2^(LIT_W-1) wraps onto itself but is
            // rejected by the range check below, so the wrap is harmless.
            assign mag = lit[gi][LIT_W-1] ? (~$unsigned(lit[gi]) + LIT_W'(1))
                                          : $unsigned(lit[gi]);

            // Variable lookup as a compare-mux so out-of-range magnitudes
            // simply select nothing.
            always_comb begin
                hit = 1'b0;
                for (int v = 0; v < NUM_VARS; v++) begin
                    if (mag == LIT_W'(v + 1)) hit = assign_reg[v];
                end
            end

            assign lit_ok[gi]  = (lit[gi] != '0) && (lit[gi] >= MIN_LIT) &&
                                 (lit[gi] <= MAX_LIT);
            // A negative literal inverts the variable; illegal ones read false.
            assign lit_val[gi] = lit_ok[gi] & (hit ^ lit[gi][LIT_W-1]);
        end
    endgenerate

    assign clause_fail = ~(lit_val[0] | lit_val[1]);
    assign lit_bad     = ~(&lit_ok);

    always_comb begin
        fail_count_next = fail_count_reg;
        first_fail_next = first_fail_reg;
        invalid_next    = invalid_reg;
        if (valid_reg) begin
            if (lit_bad) invalid_next = 1'b1;
            if (clause_fail) begin
                if (fail_count_reg == '0) first_fail_next = tag_reg;
                if (fail_count_reg != FC_MAX) fail_count_next = fail_count_reg + FW'(1);
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            assign_reg     <= '0;
            addr_reg       <= '0;
            tag_reg        <= '0;
            valid_reg      <= 1'b0;
            sat_reg        <= 1'b0;
            invalid_reg    <= 1'b0;
            fail_count_reg <= '0;
            first_fail_reg <= '0;
        end else begin
            // Read data returns one cycle after the strobe; tag it with its address.
            valid_reg <= (state_reg == ISSUE);
            tag_reg   <= addr_reg;
            if (accept) begin
                assign_reg     <= assign_val;
                addr_reg       <= '0;
                sat_reg        <= 1'b0;
                invalid_reg    <= 1'b0;
                fail_count_reg <= '0;
                first_fail_reg <= '0;
            end else begin
                fail_count_reg <= fail_count_next;
                first_fail_reg <= first_fail_next;
                invalid_reg    <= invalid_next;
                if (state_reg == ISSUE) begin
                    addr_reg <= (addr_reg == LAST_ADDR) ? '0 : addr_reg + AW'(1);
                end
                // The last clause is evaluated in DRAIN, so fold it in here.
                if (state_reg == DRAIN) begin
                    sat_reg <= (fail_count_next == '0) && !invalid_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sat_assignment_checker.sv
module tb_sat_assignment_checker;

    localparam int CS = 4;
    localparam int NV = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [NV-1:0]     assign_val;
    logic              rd_en;
    logic [1:0]        rd_addr;
    logic signed [7:0] rd_var1;
    logic signed [7:0] rd_var2;
    logic              busy;
    logic              done;
    logic              sat;
    logic [2:0]        fail_count;
    logic [1:0]        first_fail_addr;
    logic              invalid_lit;

    logic signed [7:0] mem_v1 [CS];
    logic signed [7:0] mem_v2 [CS];

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    sat_assignment_checker #(.CLAUSE_SIZE(CS), .NUM_VARS(NV), .LIT_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .assign_val(assign_val),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_var1(rd_var1),
        .rd_var2(rd_var2),
        .busy(busy),
        .done(done),
        .sat(sat),
        .fail_count(fail_count),
        .first_fail_addr(first_fail_addr),
        .invalid_lit(invalid_lit)
    );

    // Clause store with registered read.
    initial begin
        rd_var1 = '0;
        rd_var2 = '0;
    end
    always @(posedge clk) begin
        if (rd_en) begin
            rd_var1 <= mem_v1[rd_addr];
            rd_var2 <= mem_v2[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_clause(input int idx, input int a, input int b);
        mem_v1[idx] = 8'(a);
        mem_v2[idx] = 8'(b);
    endtask

    // Reference: walk the clause list, evaluate each literal by its meaning.
    task automatic model(input logic [NV-1:0] a, output bit e_sat, output int e_fc,
                         output int e_ff, output bit e_inv);
        e_fc  = 0;
        e_ff  = 0;
        e_inv = 0;
        for (int c = 0; c < CS; c++) begin
            int  l [2];
            bit  ok;
            l[0] = mem_v1[c];
            l[1] = mem_v2[c];
            ok   = 0;
            for (int k = 0; k < 2; k++) begin
                if (l[k] >= 1 && l[k] <= NV)        ok = ok | a[l[k] - 1];
                else if (l[k] <= -1 && l[k] >= -NV) ok = ok | !a[-l[k] - 1];
                else                                e_inv = 1;
            end
            if (!ok) begin
                if (e_fc == 0) e_ff = c;
                e_fc++;
            end
        end
        e_sat = (e_fc == 0) && !e_inv;
    endtask

    function automatic logic signed [7:0] rand_lit();
        int r;
        int v;
        r = $urandom_range(0, 11);
        v = 0;
        if (r < 8) begin
            v = $urandom_range(1, NV);
            if (r % 2 == 1) v = -v;
        end else if (r == 8)  v = 0;
        else if (r == 9)      v = 5;
        else if (r == 10)     v = -128;
        else                  v = -4;
        return 8'(v);
    endfunction

    // One full check: start is accepted at the edge after it is raised; cycle j
    // is the interval following that edge plus j-1 further edges.
    task automatic run_check(input logic [NV-1:0] a, input bit poke, input string tag);
        bit e_sat;
        bit e_inv;
        int e_fc;
        int e_ff;
        model(a, e_sat, e_fc, e_ff, e_inv);
        assign_val = a;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            chk("rd_en", 32'(rd_en), 32'(j <= CS));
            if (j <= CS) chk("rd_addr", 32'(rd_addr), 32'(j - 1));
            chk("busy", 32'(busy), 32'(j <= CS + 1));
            chk("done", 32'(done), 32'(j == CS + 2));
            if (j == CS + 2 || j == 8) begin
                chk("sat", 32'(sat), 32'(e_sat));
                chk("fail_count", 32'(fail_count), 32'(e_fc));
                chk("first_fail_addr", 32'(first_fail_addr), 32'(e_ff));
                chk("invalid_lit", 32'(invalid_lit), 32'(e_inv));
            end
            if (poke && j >= 1 && j <= CS) begin
                start      = 1'b1;
                assign_val = ~a;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("txn %s assign=%b poke=%0b sat=%0b fail_count=%0d first_fail=%0d invalid=%0b",
                 tag, a, poke, e_sat, e_fc, e_ff, e_inv);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'(0));
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
        chk({tag, "_sat"}, 32'(sat), 32'(0));
        chk({tag, "_fail_count"}, 32'(fail_count), 32'(0));
        chk({tag, "_first_fail"}, 32'(first_fail_addr), 32'(0));
        chk({tag, "_invalid"}, 32'(invalid_lit), 32'(0));
    endtask

    task automatic base_clauses();
        set_clause(0, 1, 2);
        set_clause(1, -1, 3);
        set_clause(2, -2, -3);
        set_clause(3, 1, -3);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        assign_val = '0;
        base_clauses();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_check(3'b101, 1'b0, "sat_101");
        run_check(3'b000, 1'b0, "unsat_000");
        run_check(3'b110, 1'b0, "unsat_110");

        set_clause(1, 0, 5);
        run_check(3'b101, 1'b0, "illegal_0_5");
        set_clause(1, -128, 1);
        run_check(3'b101, 1'b0, "illegal_m128");
        base_clauses();

        run_check(3'b101, 1'b1, "restart_ignored");

        // Reset in the middle of the clause reads.
        run_check(3'b110, 1'b0, "pre_reset");
        assign_val = 3'b000;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_cleared("midrun_reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_check(3'b110, 1'b0, "after_reset");

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < CS; c++) begin
                mem_v1[c] = rand_lit();
                mem_v2[c] = rand_lit();
            end
            run_check(3'($urandom), 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
